pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
Parameters:
REQ-001 SHALL have parameter DEPTH, default 3: number of stage registers, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 32: payload width in bits.
REQ-003 SHALL have parameter ADDR_W, default 5: destination register address width.
REQ-004 SHALL have parameter TNEW_W, default 4: result-ready countdown width.

Ports:
REQ-005 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports in_valid (1), in_data (DATA_W), in_dst (ADDR_W) and in_tnew (TNEW_W), all inputs: the instruction entering stage 0.
REQ-008 SHALL have port stall, input, DEPTH bits: stall[i] requests that stage i hold.
REQ-009 SHALL have port flush, input, DEPTH bits: flush[i] turns stage i into a bubble.
REQ-010 SHALL have ports out_valid (1), out_data (DATA_W), out_dst (ADDR_W) and out_tnew (TNEW_W), all outputs: the contents of stage DEPTH-1.
REQ-011 SHALL have port query_addr, input, ADDR_W bits: register address used for the forwarding lookup.
REQ-012 SHALL have ports fwd_hit (1), fwd_ready (1), fwd_data (DATA_W) and fwd_stage (3), all outputs: the forwarding result.
REQ-013 SHALL have port occupancy, output, 4 bits: count of valid stages.

Function
REQ-014 Each stage i SHALL hold the fields valid, data, dst and tnew; stage 0 is the youngest stage.
REQ-015 Effective hold SHALL be h[DEPTH-1] = stall[DEPTH-1], and h[i] = stall[i] | h[i+1] for lower i: a downstream stall freezes every upstream stage.
REQ-016 Per edge, stage i SHALL take the first matching action, in this priority order:
- flush[i] -> bubble;
- h[i] -> hold;
- i>0 and h[i-1] -> bubble;
- otherwise load from stage i-1 (stage 0 loads from the in_* ports).
REQ-017 A bubble SHALL be valid=0, data=0, dst=0, tnew=0.
REQ-018 Stage 0 SHALL load a bubble when in_valid=0, and SHALL force dst=0 and tnew=0 when in_valid=0.
REQ-019 Every load and every hold of a valid stage SHALL store the saturating decrement of its source tnew: value-1, floored at 0.
REQ-020 Because of REQ-019, tnew SHALL keep counting down while a stage is stalled, and SHALL never wrap from 0.
REQ-021 Data, dst and valid SHALL be unchanged across a hold.
REQ-022 Pipeline latency with no stall and no flush SHALL be DEPTH edges from in_* to out_*.
REQ-023 out_* SHALL be driven directly from the stage DEPTH-1 registers, with no combinational path from the inputs.
REQ-024 Forwarding lookup, combinational from the stage registers only:
- if query_addr==0, fwd_hit=0;
- otherwise fwd_hit=1 when some valid stage has dst==query_addr;
- when several stages match, the lowest index (youngest) wins.
REQ-025 On a hit, fwd_stage SHALL be the winning index, fwd_data its data, and fwd_ready=1 exactly when its tnew==0.
REQ-026 On a miss, fwd_stage, fwd_data and fwd_ready SHALL all be 0.
REQ-027 occupancy SHALL be the population count of the valid bits, combinational, range 0..DEPTH.
REQ-028 A simultaneous flush[i] and stall[i] SHALL yield a bubble in stage i; upstream stages still obey h.
REQ-029 An upstream stage SHALL NOT be flushed by a flush on a downstream stage.

Reset
REQ-030 While reset=1 at an edge, every stage SHALL become a bubble, regardless of stall, flush or in_*.
REQ-031 After reset: out_valid=0, out_data=0, out_dst=0, out_tnew=0, fwd_hit=0, fwd_ready=0, fwd_data=0, fwd_stage=0, occupancy=0.
REQ-032 Reset asserted mid-operation SHALL discard all stage contents at that edge.

Verification (DEPTH=3, DATA_W=32)
REQ-033 Flow-through: inject one instruction (in_valid=1, data=0x12345678, dst=5, tnew=2) for one cycle, with no stall and no flush.
- out_valid=1 after exactly 3 edges;
- out_data=0x12345678, out_dst=5, out_tnew=0, since tnew steps 2->1->0->0;
- out_valid=0 on the following edge.
REQ-034 Stall countdown: stage 2 holds data=0xA, tnew=3, and stall[2]=1 for 2 edges.
- stage 2 data stays 0xA while its tnew steps 3->2->1;
- stages 0 and 1 are frozen;
- in_* is ignored during the stall.
REQ-035 Bubble insertion: stall=3'b010 for 1 edge with all stages valid.
- stages 0 and 1 hold;
- stage 2 becomes a bubble: out_valid=0 after that edge;
- occupancy drops from 3 to 2.
REQ-036 Flush priority: flush[0]=1 and stall[0]=1 in the same cycle, with stage 0 valid.
- stage 0 valid=0 and dst=0 on the next edge.
REQ-037 Forwarding priority:
- stage 0 holds dst=8, tnew=1, data=0x1; stage 2 holds dst=8, tnew=0, data=0x2;
- query_addr=8 -> fwd_hit=1, fwd_stage=0, fwd_data=0x1, fwd_ready=0;
- query_addr=0 -> fwd_hit=0;
- query_addr=9 (no match) -> fwd_hit=0, fwd_data=0.
REQ-038 Reset mid-operation: with all stages valid and stall=3'b111, assert reset for 1 edge.
- occupancy=0, out_valid=0 and fwd_hit=0 for every query_addr;
- the next injected instruction appears at out_* after 3 edges.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Purpose: chain of DEPTH instruction stage registers with per-stage stall/flush and a forwarding lookup.
// Latency: DEPTH edges from in_* to out_* when nothing stalls; fwd_* and occupancy are combinational from the stages.
// Backpressure: stall[i] holds stage i and every stage upstream of it; a held stage inserts a bubble just below it.
module pipe_reg_chain #(
   parameter int DEPTH  = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TNEW_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_dst,
   input  logic [TNEW_W-1:0] in_tnew,
   input  logic [DEPTH-1:0]  stall,
   input  logic [DEPTH-1:0]  flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_dst,
   output logic [TNEW_W-1:0] out_tnew,
   input  logic [ADDR_W-1:0] query_addr,
   output logic              fwd_hit,
   output logic              fwd_ready,
   output logic [DATA_W-1:0] fwd_data,
   output logic [2:0]        fwd_stage,
   output logic [3:0]        occupancy
);

   typedef struct packed {
      logic              vld;
      logic [DATA_W-1:0] dat;
      logic [ADDR_W-1:0] dst;
      logic [TNEW_W-1:0] tnew;
   } stage_t;

   localparam stage_t BUBBLE = '0;

   stage_t           st_q [DEPTH];
   stage_t           st_d [DEPTH];
   logic [DEPTH-1:0] hold;

   // result-ready countdown never wraps below zero
   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // a stage holds when it or any stage downstream of it is stalled
   for (genvar g = 0; g < DEPTH; g++) begin : g_hold
      assign hold[g] = |stall[DEPTH-1:g];
   end

   // next-state selection: flush, then hold, then bubble behind a hold, then load
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         st_d[i] = BUBBLE;
      end
      if (flush[0]) begin
         st_d[0] = BUBBLE;
      end else if (hold[0]) begin
         st_d[0]      = st_q[0];
         st_d[0].tnew = tnew_dec(st_q[0].tnew);
      end else if (in_valid) begin
         st_d[0].vld  = 1'b1;
         st_d[0].dat  = in_data;
         st_d[0].dst  = in_dst;
         st_d[0].tnew = tnew_dec(in_tnew);
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (flush[i]) begin
            st_d[i] = BUBBLE;
         end else if (hold[i]) begin
            st_d[i]      = st_q[i];
            st_d[i].tnew = tnew_dec(st_q[i].tnew);
         end else if (hold[i-1]) begin
            st_d[i] = BUBBLE;
         end else begin
            st_d[i]      = st_q[i-1];
            st_d[i].tnew = tnew_dec(st_q[i-1].tnew);
         end
      end
   end

   // stage registers; reset empties the whole chain regardless of stall/flush
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            st_q[i] <= BUBBLE;
         end else begin
            st_q[i] <= st_d[i];
         end
      end
   end

   assign out_valid = st_q[DEPTH-1].vld;
   assign out_data  = st_q[DEPTH-1].dat;
   assign out_dst   = st_q[DEPTH-1].dst;
   assign out_tnew  = st_q[DEPTH-1].tnew;

   // forwarding lookup: scan oldest to youngest so the youngest match wins; address 0 never hits
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_ready = 1'b0;
      fwd_data  = '0;
      fwd_stage = '0;
      if (query_addr != '0) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (st_q[i].vld && (st_q[i].dst == query_addr)) begin
               fwd_hit   = 1'b1;
               fwd_ready = (st_q[i].tnew == '0);
               fwd_data  = st_q[i].dat;
               fwd_stage = 3'(i);
            end
         end
      end
   end

   // number of occupied stages
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + 4'(st_q[i].vld);
      end
   end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Purpose: scoreboard bench for pipe_reg_chain (DEPTH=3) with directed scenarios and random traffic.
// Latency: expected outputs are queued once per cycle and popped by the monitor on the falling edge.
// Backpressure: random stall/flush/reset patterns are applied and mirrored by the reference model.
module tb_pipe_reg_chain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [4:0]  in_dst = '0;
   logic [3:0]  in_tnew = '0;
   logic [2:0]  stall = '0;
   logic [2:0]  flush = '0;
   logic [4:0]  query_addr = '0;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_dst;
   logic [3:0]  out_tnew;
   logic        fwd_hit;
   logic        fwd_ready;
   logic [31:0] fwd_data;
   logic [2:0]  fwd_stage;
   logic [3:0]  occupancy;

   int total = 0;
   int bad   = 0;

   pipe_reg_chain #(.DEPTH(3), .DATA_W(32), .ADDR_W(5), .TNEW_W(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_dst(in_dst), .in_tnew(in_tnew),
      .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst), .out_tnew(out_tnew),
      .query_addr(query_addr),
      .fwd_hit(fwd_hit), .fwd_ready(fwd_ready), .fwd_data(fwd_data), .fwd_stage(fwd_stage),
      .occupancy(occupancy)
   );

   always #10 clk = ~clk;

   // expected snapshot of all outputs for one cycle
   typedef struct {
      logic        v;
      logic [31:0] d;
      logic [4:0]  dst;
      logic [3:0]  t;
      logic [3:0]  occ;
      logic        hit;
      logic [2:0]  stg;
      logic [31:0] fd;
      logic        rdy;
   } exp_t;

   exp_t sb[$];

   // reference pipeline contents, index 0 youngest
   logic        mv   [3];
   logic [31:0] md   [3];
   logic [4:0]  mdst [3];
   int          mt   [3];
   logic [4:0]  drv_q = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // one clock: wait for the edge, drive new inputs, queue expectation, advance the model
   task automatic cycle(input logic iv, input logic [31:0] id, input logic [4:0] idst,
                        input logic [3:0] itn, input logic [2:0] st, input logic [2:0] fl,
                        input logic [4:0] q, input logic rst);
      exp_t        e;
      bit          hld [3];
      logic        nv   [3];
      logic [31:0] nd   [3];
      logic [4:0]  ndst [3];
      int          nt   [3];
      @(posedge clk);
      #1;
      in_valid = iv; in_data = id; in_dst = idst; in_tnew = itn;
      stall = st; flush = fl; query_addr = q; drv_q = q; reset = rst;

      e.v = mv[2]; e.d = md[2]; e.dst = mdst[2]; e.t = 4'(mt[2]);
      e.occ = 4'(int'(mv[0]) + int'(mv[1]) + int'(mv[2]));
      e.hit = 1'b0; e.stg = '0; e.fd = '0; e.rdy = 1'b0;
      if (q != 0) begin
         for (int i = 2; i >= 0; i--) begin
            if (mv[i] && mdst[i] == q) begin
               e.hit = 1'b1; e.stg = 3'(i); e.fd = md[i]; e.rdy = (mt[i] == 0);
            end
         end
      end
      sb.push_back(e);

      for (int i = 0; i < 3; i++) begin
         hld[i] = 1'b0;
         for (int j = i; j < 3; j++) if (st[j]) hld[i] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         nv[i] = 1'b0; nd[i] = '0; ndst[i] = '0; nt[i] = 0;
         if (rst || fl[i]) begin
            // bubble
         end else if (hld[i]) begin
            nv[i] = mv[i]; nd[i] = md[i]; ndst[i] = mdst[i];
            nt[i] = (mt[i] > 0) ? mt[i] - 1 : 0;
         end else if (i > 0 && hld[i-1]) begin
            // bubble behind a held stage
         end else if (i == 0) begin
            if (iv) begin
               nv[0] = 1'b1; nd[0] = id; ndst[0] = idst;
               nt[0] = (int'(itn) > 0) ? int'(itn) - 1 : 0;
            end
         end else begin
            nv[i] = mv[i-1]; nd[i] = md[i-1]; ndst[i] = mdst[i-1];
            nt[i] = (mt[i-1] > 0) ? mt[i-1] - 1 : 0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         mv[i] = nv[i]; md[i] = nd[i]; mdst[i] = ndst[i]; mt[i] = nt[i];
      end
   endtask

   task automatic idle(input logic [2:0] st, input logic [4:0] q);
      cycle(1'b0, 32'h0, 5'd0, 4'd0, st, 3'b000, q, 1'b0);
   endtask

   // look up one address between edges, then restore the driven query
   task automatic probe(input string nm, input logic [4:0] q, input logic hit,
                        input logic [2:0] stg, input logic [31:0] dat, input logic rdy);
      query_addr = q;
      #1;
      chk({nm, " hit"},   64'(fwd_hit),   64'(hit));
      chk({nm, " stage"}, 64'(fwd_stage), 64'(stg));
      chk({nm, " data"},  64'(fwd_data),  64'(dat));
      chk({nm, " ready"}, 64'(fwd_ready), 64'(rdy));
      query_addr = drv_q;
   endtask

   // monitor: compare DUT outputs to the queued expectation each falling edge
   initial begin
      int n = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n++;
            chk($sformatf("c%0d out_valid", n), 64'(out_valid), 64'(e.v));
            chk($sformatf("c%0d out_data", n),  64'(out_data),  64'(e.d));
            chk($sformatf("c%0d out_dst", n),   64'(out_dst),   64'(e.dst));
            chk($sformatf("c%0d out_tnew", n),  64'(out_tnew),  64'(e.t));
            chk($sformatf("c%0d occupancy", n), 64'(occupancy), 64'(e.occ));
            chk($sformatf("c%0d fwd_hit", n),   64'(fwd_hit),   64'(e.hit));
            chk($sformatf("c%0d fwd_stage", n), 64'(fwd_stage), 64'(e.stg));
            chk($sformatf("c%0d fwd_data", n),  64'(fwd_data),  64'(e.fd));
            chk($sformatf("c%0d fwd_ready", n), 64'(fwd_ready), 64'(e.rdy));
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         mv[i] = 1'b0; md[i] = '0; mdst[i] = '0; mt[i] = 0;
      end

      // reset state
      cycle(1'b0, 32'h0, 5'd0, 4'd0, 3'b000, 3'b000, 5'd0, 1'b1);
      cycle(1'b0, 32'h0, 5'd0, 4'd0, 3'b000, 3'b000, 5'd0, 1'b1);
      #1;
      chk("rst occupancy", 64'(occupancy), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_data",  64'(out_data),  64'd0);
      chk("rst out_tnew",  64'(out_tnew),  64'd0);
      probe("rst q5", 5'd5, 1'b0, 3'd0, 32'h0, 1'b0);

      // flow-through, tnew 2->1->0->0
      cycle(1'b1, 32'h12345678, 5'd5, 4'd2, 3'b000, 3'b000, 5'd5, 1'b0);
      idle(3'b000, 5'd5);
      idle(3'b000, 5'd5);
      #1 chk("flow early out_valid", 64'(out_valid), 64'd0);
      idle(3'b000, 5'd5);
      #1;
      chk("flow out_valid", 64'(out_valid), 64'd1);
      chk("flow out_data",  64'(out_data),  64'h12345678);
      chk("flow out_dst",   64'(out_dst),   64'd5);
      chk("flow out_tnew",  64'(out_tnew),  64'd0);
      idle(3'b000, 5'd0);
      #1 chk("flow drained out_valid", 64'(out_valid), 64'd0);

      // stall countdown: stage 2 holds 0xA with tnew 3
      cycle(1'b1, 32'hA, 5'd1, 4'd6, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'hB, 5'd2, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'hC, 5'd3, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'hEE, 5'd7, 4'd9, 3'b100, 3'b000, 5'd0, 1'b0);
      #1;
      chk("stall t3 data", 64'(out_data), 64'hA);
      chk("stall t3 tnew", 64'(out_tnew), 64'd3);
      cycle(1'b1, 32'hEF, 5'd7, 4'd9, 3'b100, 3'b000, 5'd0, 1'b0);
      #1;
      chk("stall t2 data", 64'(out_data), 64'hA);
      chk("stall t2 tnew", 64'(out_tnew), 64'd2);
      cycle(1'b1, 32'h11, 5'd11, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      #1;
      chk("stall t1 data", 64'(out_data), 64'hA);
      chk("stall t1 tnew", 64'(out_tnew), 64'd1);
      probe("stall frozen s1", 5'd2, 1'b1, 3'd1, 32'hB, 1'b1);
      probe("stall frozen s0", 5'd3, 1'b1, 3'd0, 32'hC, 1'b1);
      probe("stall ignored in", 5'd7, 1'b0, 3'd0, 32'h0, 1'b0);

      // bubble insertion with stall=010
      cycle(1'b1, 32'h12, 5'd12, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'h13, 5'd13, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'h14, 5'd14, 4'd0, 3'b010, 3'b000, 5'd0, 1'b0);
      #1 chk("bubble occ before", 64'(occupancy), 64'd3);
      // flush and stall on stage 0 together
      cycle(1'b0, 32'h0, 5'd0, 4'd0, 3'b001, 3'b001, 5'd0, 1'b0);
      #1;
      chk("bubble out_valid", 64'(out_valid), 64'd0);
      chk("bubble occ after", 64'(occupancy), 64'd2);
      probe("bubble s1 held", 5'd12, 1'b1, 3'd1, 32'h12, 1'b1);
      cycle(1'b1, 32'h2, 5'd8, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      #1;
      chk("flush occ", 64'(occupancy), 64'd1);
      chk("flush out_dst", 64'(out_dst), 64'd12);
      probe("flush s0 gone", 5'd13, 1'b0, 3'd0, 32'h0, 1'b0);

      // forwarding priority: stage0 dst8/tnew1/0x1, stage2 dst8/tnew0/0x2
      cycle(1'b1, 32'h3, 5'd4, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'h1, 5'd8, 4'd2, 3'b000, 3'b000, 5'd0, 1'b0);
      cycle(1'b1, 32'h77, 5'd9, 4'd0, 3'b111, 3'b000, 5'd8, 1'b1);
      #1;
      probe("fwd q8", 5'd8, 1'b1, 3'd0, 32'h1, 1'b0);
      probe("fwd q0", 5'd0, 1'b0, 3'd0, 32'h0, 1'b0);
      probe("fwd q9", 5'd9, 1'b0, 3'd0, 32'h0, 1'b0);
      probe("fwd q4", 5'd4, 1'b1, 3'd1, 32'h3, 1'b1);

      // reset mid-operation under full stall, then inject
      cycle(1'b1, 32'hCAFE, 5'd6, 4'd1, 3'b000, 3'b000, 5'd6, 1'b0);
      #1;
      chk("midrst occupancy", 64'(occupancy), 64'd0);
      chk("midrst out_valid", 64'(out_valid), 64'd0);
      probe("midrst q8", 5'd8, 1'b0, 3'd0, 32'h0, 1'b0);
      probe("midrst q4", 5'd4, 1'b0, 3'd0, 32'h0, 1'b0);
      probe("midrst q9", 5'd9, 1'b0, 3'd0, 32'h0, 1'b0);
      idle(3'b000, 5'd6);
      idle(3'b000, 5'd6);
      #1 chk("midrst early out_valid", 64'(out_valid), 64'd0);
      idle(3'b000, 5'd6);
      #1;
      chk("midrst out_valid", 64'(out_valid), 64'd1);
      chk("midrst out_data",  64'(out_data),  64'hCAFE);
      chk("midrst out_tnew",  64'(out_tnew),  64'd0);

      // random traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         logic [2:0] st;
         logic [2:0] fl;
         for (int b = 0; b < 3; b++) begin
            st[b] = ($urandom_range(0, 5) == 0);
            fl[b] = ($urandom_range(0, 7) == 0);
         end
         cycle(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), st, fl, 5'($urandom_range(0, 7)),
               ($urandom_range(0, 99) == 0));
      end

      @(negedge clk);
      #1;
      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
